// File: rtl/instfetch.sv
// Instruction fetch stage: PC register, direct-mapped I-cache with a single
// outstanding refill, and ROB redirect handling feeding the instruction queue.
module instfetch #(
  parameter int          ICacheLines = 16,
  parameter int          IndexWidth  = 4,
  parameter logic [31:0] ResetPC     = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  output logic        if_mem_req_out,
  output logic [31:0] if_mem_addr_out,
  input  logic        mem_if_valid_in,
  input  logic [31:0] mem_if_data_in,
  input  logic        instqueue_if_rdy_in,
  output logic        if_instqueue_en_out,
  output logic [31:0] if_instqueue_inst_out,
  output logic [31:0] if_instqueue_pc_out,
  input  logic        rob_if_rst_in,
  input  logic [31:0] rob_if_pc_in
);

  localparam int TagWidth = 30 - IndexWidth;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    MISS    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [31:0]           pc, pc_next;
  logic [31:0]           mem_addr, mem_addr_next;
  logic                  mem_req, mem_req_next;
  logic                  push_en, push_en_next;
  logic [31:0]           push_inst, push_inst_next;
  logic [31:0]           push_pc, push_pc_next;
  logic                  fill;

  logic [ICacheLines-1:0] line_valid;
  logic [TagWidth-1:0]    line_tag  [ICacheLines];
  logic [31:0]            line_data [ICacheLines];

  logic [IndexWidth-1:0] lookup_idx, fill_idx;
  logic [TagWidth-1:0]   lookup_tag, fill_tag;
  logic                  hit;

  assign lookup_idx = pc[IndexWidth+1:2];
  assign lookup_tag = pc[31:2+IndexWidth];
  assign fill_idx   = mem_addr[IndexWidth+1:2];
  assign fill_tag   = mem_addr[31:2+IndexWidth];
  assign hit        = line_valid[lookup_idx] && (line_tag[lookup_idx] == lookup_tag);

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    mem_addr_next  = mem_addr;
    mem_req_next   = mem_req;
    push_en_next   = 1'b0;
    push_inst_next = push_inst;
    push_pc_next   = push_pc;
    fill           = 1'b0;

    // A returning refill is always written, even if a redirect coincides.
    if (state != FETCH && mem_if_valid_in) begin
      fill         = 1'b1;
      mem_req_next = 1'b0;
      state_next   = FETCH;
    end

    if (rob_if_rst_in) begin
      pc_next = rob_if_pc_in;
      if (state != FETCH && !mem_if_valid_in) state_next = DISCARD;
    end else begin
      unique case (state)
        FETCH: begin
          if (hit) begin
            if (instqueue_if_rdy_in) begin
              push_en_next   = 1'b1;
              push_inst_next = line_data[lookup_idx];
              push_pc_next   = pc;
              pc_next        = pc + 32'd4;
            end
          end else begin
            state_next    = MISS;
            mem_addr_next = {pc[31:2], 2'b00};
            mem_req_next  = 1'b1;
          end
        end
        MISS, DISCARD: begin
        end
        default: state_next = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= FETCH;
      pc         <= ResetPC;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      push_en    <= 1'b0;
      push_inst  <= '0;
      push_pc    <= '0;
      line_valid <= '0;
    end else if (rdy_in) begin
      state     <= state_next;
      pc        <= pc_next;
      mem_addr  <= mem_addr_next;
      mem_req   <= mem_req_next;
      push_en   <= push_en_next;
      push_inst <= push_inst_next;
      push_pc   <= push_pc_next;
      if (fill) line_valid[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone qualify them.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill) begin
      line_tag[fill_idx]  <= fill_tag;
      line_data[fill_idx] <= mem_if_data_in;
    end
  end

  assign if_mem_req_out        = mem_req;
  assign if_mem_addr_out       = mem_addr;
  assign if_instqueue_en_out   = push_en && rdy_in;
  assign if_instqueue_inst_out = push_inst;
  assign if_instqueue_pc_out   = push_pc;

endmodule

// File: doc/instfetch.md
# instfetch

Instruction fetch stage, upstream of the instruction queue. It holds the program counter and looks each fetch address up in a small direct-mapped instruction cache. On a hit it pushes one {instruction, PC} pair per cycle into the queue; on a miss it runs a single-outstanding refill from the memory controller. A reorder-buffer redirect flushes in-flight work and restarts fetch at the supplied PC.

## Interface
- `ICacheLines`, default 16: number of direct-mapped lines, one 32-bit word each; must be a power of two.
- `IndexWidth`, default 4: log2(`ICacheLines`). Tag width is 30 − `IndexWidth`, taken from PC[31:2+`IndexWidth`].
- `ResetPC`, default 32'h0: PC loaded at reset.
- `clk_in` input 1: the single clock; all state changes on its rising edge.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `rdy_in` input 1: global enable. When low, all state holds and `if_instqueue_en_out` is forced to 0.
- `if_mem_req_out` output 1: refill request, held high while a refill is outstanding.
- `if_mem_addr_out` output 32: word-aligned refill address; stable while `if_mem_req_out` is high.
- `mem_if_valid_in` input 1: one-cycle pulse; the refill data is valid this cycle.
- `mem_if_data_in` input 32: refill instruction word.
- `instqueue_if_rdy_in` input 1: the queue can accept one entry at the next edge.
- `if_instqueue_en_out` output 1: registered push strobe.
- `if_instqueue_inst_out` output 32: registered instruction.
- `if_instqueue_pc_out` output 32: registered PC of that instruction.
- `rob_if_rst_in` input 1: redirect or flush request.
- `rob_if_pc_in` input 32: redirect target, sampled when `rob_if_rst_in` is high.

## Operation
- **Reset values** (asynchronous, while `rst_n_in` is 0):
  - PC = `ResetPC`; state = FETCH; all cache valid bits = 0.
  - `if_mem_req_out`, `if_instqueue_en_out` = 0.
  - `if_mem_addr_out`, `if_instqueue_inst_out`, `if_instqueue_pc_out` = 0.
- **State machine** (FETCH, MISS, DISCARD):
  - FETCH:
    - Cache hit and `instqueue_if_rdy_in` = 1: register inst/PC/en = 1, PC += 4.
    - Hit with queue not ready: en = 0, PC holds.
    - Miss: go to MISS, set `if_mem_addr_out` = {PC[31:2], 2'b00}, set `if_mem_req_out` = 1, en = 0.
  - MISS: wait for `mem_if_valid_in`. On the valid cycle, write the line (data, tag, valid = 1), drop `if_mem_req_out`, and return to FETCH; the next cycle hits.
  - DISCARD: a redirect arrived during MISS. Request stays high with the old address until `mem_if_valid_in`. The data is still written to the cache (it is correct for that address), then return to FETCH at the redirected PC.
- **Redirect priority:** `rob_if_rst_in` beats every other event in the same cycle except reset.
  - PC ← `rob_if_pc_in` and en ← 0.
  - FETCH stays FETCH; MISS goes to DISCARD; DISCARD stays DISCARD.
  - If `mem_if_valid_in` and redirect coincide in MISS or DISCARD: fill the line and go to FETCH with the new PC.
- **Arithmetic:** PC + 4 wraps modulo 2^32. PC[1:0] is ignored for lookup and request.
- **Cache coherence:** no invalidation other than reset; self-modifying code is unsupported.
- **Outstanding refills:** at most one; there is no cancellation of an issued refill.

## Timing
- **Hit path:** PC presented in cycle N; `if_instqueue_en_out` is high in cycle N+1. Sustained rate is 1 instruction per cycle on hits with the queue ready.
- **Miss path:**
  - Lookup in cycle N; `if_mem_req_out` rises at N+1.
  - Memory valid arrives at cycle M; request falls at M+1; push at M+2.
- **Redirect:** asserted in cycle R; the first lookup at the target happens in R+1; the earliest push is R+2. A push registered in cycle R is discarded by the flushed queue.
- **Memory contract:**
  - The controller may sample `if_mem_addr_out` on any cycle while `if_mem_req_out` is high.
  - It returns exactly one `mem_if_valid_in` per request, no earlier than the cycle after the request rises.
- **`rdy_in` = 0:** freezes state, PC, the cache and the request line. A `mem_if_valid_in` pulse while frozen is lost, so the memory controller is held by the same `rdy_in`.

## Test plan
- **Cold start:** release reset with `ResetPC` = 0 and memory latency 3. Required: request at address 0x0 rises 1 cycle after release; refill data 0x00000013; push {0x00000013, pc 0x0} two cycles after valid; then a miss for 0x4.
- **Hit streaming:** preload 0x0–0x3C via misses, then redirect to 0x0. Required: 16 consecutive pushes, PCs 0x0…0x3C, one per cycle, with no request.
- **Backpressure:** during streaming, drop `instqueue_if_rdy_in` for 3 cycles at PC 0x10. Required: en = 0 for those cycles; resume at 0x10 with no skipped or duplicated PC.
- **Redirect during miss:** miss at 0x100, then redirect to 0x40 two cycles later; memory returns 5 cycles after the request.
  - Required: request stays at 0x100 until valid; line 0 is filled with tag for 0x100; no push of 0x100.
  - Next request is for 0x40 (if not cached), and the first push is pc 0x40.
- **Conflict and alias:** fetch 0x0, then 0x40 (same index, 16 lines). Required: 0x40 misses and replaces the line; re-fetching 0x0 misses again.
- **Reset mid-miss:** assert `rst_n_in` low while in MISS. Required: `if_mem_req_out` drops immediately (asynchronously); after release all lines miss and fetch restarts at `ResetPC`.
